// File: rtl/spi_slave_byte.sv
// spi_slave_byte: SPI responder for byte transfers. SCLK, CS_n and MOSI are
// oversampled in the i_Clk domain. Received bytes are shifted in MSB first and
// flagged with a one-cycle valid pulse. MISO returns a byte from a
// single-entry holding register, or 8'hFF when that register is empty.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | CS_n high: SCLK edges ignored, MISO pad released
// ACTIVE | CS_n low: sampling MOSI, shifting MISO, byte boundaries live
module spi_slave_byte #(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Underrun,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = (SPI_MODE == 2) || (SPI_MODE == 3);
  localparam logic CPHA = (SPI_MODE == 1) || (SPI_MODE == 3);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   leading, trailing, sample_edge, shift_edge;
  logic                   cs_fall, cs_rise, active;
  logic                   frame_start, bit_sample, boundary;
  logic [7:0]             boundary_byte;

  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift;
  logic                   rx_done;
  logic [7:0]             tx_hold;
  logic [7:0]             tx_shift;

  // Input synchronizers; SCLK idles at CPOL so no false edge appears out of reset.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_sync <= {SYNC_STAGES{CPOL}};
      cs_sync   <= {SYNC_STAGES{1'b1}};
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_Clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Delayed copies of synchronized SCLK and CS_n for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sclk_d <= CPOL;
      cs_d   <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign leading     = (sclk_s != CPOL) && (sclk_d == CPOL);
  assign trailing    = (sclk_s == CPOL) && (sclk_d != CPOL);
  assign sample_edge = CPHA ? trailing : leading;
  assign shift_edge  = CPHA ? leading : trailing;
  assign cs_fall     = cs_d && !cs_s;
  assign cs_rise     = !cs_d && cs_s;

  // Frame state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: CS_n alone opens and closes a frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign active        = (state_q == ST_ACTIVE);
  assign frame_start   = !active && cs_fall;
  assign bit_sample    = active && !cs_rise && sample_edge;
  assign boundary      = frame_start || (active && !cs_rise && rx_done);
  assign boundary_byte = o_TX_Ready ? 8'hFF : tx_hold;
  assign o_SPI_MISO_En = active;

  // Receive path: bit counter, MOSI shift register and the valid pulse one
  // cycle after the final sample of each byte.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bit_cnt   <= 3'd7;
      rx_shift  <= 8'h00;
      rx_done   <= 1'b0;
      o_RX_DV   <= 1'b0;
      o_RX_Byte <= 8'h00;
    end else begin
      rx_done <= bit_sample && (bit_cnt == 3'd0);
      o_RX_DV <= rx_done;
      if (rx_done) o_RX_Byte <= rx_shift;
      if (frame_start || (active && cs_rise)) begin
        bit_cnt <= 3'd7;
      end else if (bit_sample) begin
        rx_shift[bit_cnt] <= mosi_s;
        bit_cnt           <= bit_cnt - 3'd1;
      end
    end
  end

  // Transmit path: holding register handshake, boundary loads and MISO shifting.
  // With CPHA=0 the first bit of a frame must be on the wire before the first
  // leading edge, so the frame-start load drives bit 7 immediately; mid-frame
  // loads are shifted out by the trailing edge that closes the previous byte.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      tx_hold       <= 8'h00;
      o_TX_Ready    <= 1'b1;
      tx_shift      <= 8'h00;
      o_TX_Underrun <= 1'b0;
      o_SPI_MISO    <= 1'b0;
    end else begin
      o_TX_Underrun <= boundary && o_TX_Ready;
      if (boundary) begin
        if (!o_TX_Ready) o_TX_Ready <= 1'b1;
        if (frame_start && !CPHA) begin
          o_SPI_MISO <= boundary_byte[7];
          tx_shift   <= {boundary_byte[6:0], 1'b0};
        end else begin
          tx_shift <= boundary_byte;
        end
      end else if (active && !cs_rise && shift_edge) begin
        o_SPI_MISO <= tx_shift[7];
        tx_shift   <= {tx_shift[6:0], 1'b0};
      end
      // Evaluated against the pre-boundary ready flag: a byte offered while
      // the boundary finds the register empty is kept for the next byte.
      if (i_TX_DV && o_TX_Ready) begin
        tx_hold    <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_byte.sv
// tb_spi_slave_byte: one responder per SPI mode driven by a behavioural
// master; directed scenarios with hand-computed expected bytes.
module tb_spi_slave_byte;

  localparam int H  = 4;   // SCLK half period in i_Clk cycles (SCLK = i_Clk/8)
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [3:0] sclk, cs_n, mosi, miso, miso_en, rx_dv, tx_dv, tx_ready, underrun;
  logic [7:0] rx_byte [4];
  logic [7:0] tx_byte [4];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int dv_cnt [4] = '{default: 0};
  int ur_cnt [4] = '{default: 0};
  int dv_cyc [4] = '{default: 0};
  int edge_cyc [4] = '{default: 0};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rx_dv[i]) begin
        dv_cnt[i] <= dv_cnt[i] + 1;
        dv_cyc[i] <= cyc;
      end
      if (underrun[i]) ur_cnt[i] <= ur_cnt[i] + 1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_byte #(.SPI_MODE(g), .SYNC_STAGES(SS)) u_dut (
      .i_Clk         (clk),
      .i_Rst_L       (rst_l),
      .o_RX_DV       (rx_dv[g]),
      .o_RX_Byte     (rx_byte[g]),
      .i_TX_DV       (tx_dv[g]),
      .i_TX_Byte     (tx_byte[g]),
      .o_TX_Ready    (tx_ready[g]),
      .o_TX_Underrun (underrun[g]),
      .i_SPI_Clk     (sclk[g]),
      .i_SPI_CS_n    (cs_n[g]),
      .i_SPI_MOSI    (mosi[g]),
      .o_SPI_MISO    (miso[g]),
      .o_SPI_MISO_En (miso_en[g])
    );
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_load(input int m, input logic [7:0] b);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (tx_ready[m]) begin
        tx_byte[m] = b;
        tx_dv[m]   = 1'b1;
        tick(1);
        tx_dv[m]   = 1'b0;
        done       = 1'b1;
      end else begin
        tick(1);
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL tx_load_timeout mode%0d: o_TX_Ready=0 for 3000 cycles, required 1", m);
    end
  endtask

  task automatic cs_low(input int m);
    cs_n[m] = 1'b0;
    tick(H);
  endtask

  task automatic cs_high(input int m);
    tick(H);
    cs_n[m] = 1'b1;
    tick(3 * H);
  endtask

  // Master side of one byte (or its first nbits), MSB first.
  task automatic xfer(input int m, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic cpol, cpha;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    rx   = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi[m] = tx[i];
        tick(H);
        sclk[m] = ~cpol;
        rx[i] = miso[m];
        edge_cyc[m] = cyc;
        tick(H);
        sclk[m] = cpol;
      end else begin
        tick(H);
        sclk[m] = ~cpol;
        mosi[m] = tx[i];
        tick(H);
        sclk[m] = cpol;
        rx[i] = miso[m];
        edge_cyc[m] = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    tick(3);
    for (int m = 0; m < 4; m++) begin
      tests++;
      if ({rx_dv[m], rx_byte[m], tx_ready[m], underrun[m], miso[m], miso_en[m]} !== 13'b0_00000000_1_0_0_0) begin
        fails++;
        $display("FAIL reset_values mode%0d: dv=%b rx=%h rdy=%b ur=%b miso=%b en=%b, required 0 00 1 0 0 0",
                 m, rx_dv[m], rx_byte[m], tx_ready[m], underrun[m], miso[m], miso_en[m]);
      end
    end
    rst_l = 1'b1;
    tick(3);
  endtask

  task automatic test_mode0_basic();
    logic [7:0] r;
    int d0;
    tx_load(0, 8'h3C);
    d0 = dv_cnt[0];
    cs_low(0);
    xfer(0, 8'hA5, 8, r);
    cs_high(0);
    tests++;
    if (rx_byte[0] !== 8'hA5) begin fails++; $display("FAIL m0_rx_byte: got %h, required a5", rx_byte[0]); end
    tests++;
    if (dv_cnt[0] - d0 !== 1) begin fails++; $display("FAIL m0_dv_pulses: got %0d, required 1", dv_cnt[0] - d0); end
    tests++;
    if (r !== 8'h3C) begin fails++; $display("FAIL m0_miso_byte: got %h, required 3c", r); end
    tests++;
    if (dv_cyc[0] - edge_cyc[0] !== SS + 2) begin
      fails++; $display("FAIL m0_dv_latency: got %0d, required %0d", dv_cyc[0] - edge_cyc[0], SS + 2);
    end
  endtask

  task automatic test_modes();
    logic [7:0] mo_v [2];
    logic [7:0] mi_v [2];
    logic [7:0] r;
    int d0;
    mo_v[0] = 8'h81; mi_v[0] = 8'h81;
    mo_v[1] = 8'h35; mi_v[1] = 8'hC6;
    for (int m = 1; m < 4; m++) begin
      for (int v = 0; v < 2; v++) begin
        tx_load(m, mi_v[v]);
        d0 = dv_cnt[m];
        cs_low(m);
        xfer(m, mo_v[v], 8, r);
        cs_high(m);
        tests++;
        if (rx_byte[m] !== mo_v[v]) begin fails++; $display("FAIL mode%0d_rx_byte: got %h, required %h", m, rx_byte[m], mo_v[v]); end
        tests++;
        if (r !== mi_v[v]) begin fails++; $display("FAIL mode%0d_miso_byte: got %h, required %h", m, r, mi_v[v]); end
        tests++;
        if (dv_cnt[m] - d0 !== 1) begin fails++; $display("FAIL mode%0d_dv_pulses: got %0d, required 1", m, dv_cnt[m] - d0); end
        tests++;
        if (dv_cyc[m] - edge_cyc[m] !== SS + 2) begin
          fails++; $display("FAIL mode%0d_dv_latency: got %0d, required %0d", m, dv_cyc[m] - edge_cyc[m], SS + 2);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] mo_v [3];
    logic [7:0] mi_v [3];
    logic [7:0] r;
    int d0;
    mo_v[0] = 8'h11; mo_v[1] = 8'h22; mo_v[2] = 8'h33;
    mi_v[0] = 8'hC3; mi_v[1] = 8'h44; mi_v[2] = 8'h55;
    tx_load(0, 8'hC3);
    d0 = dv_cnt[0];
    fork
      begin
        cs_low(0);
        for (int b = 0; b < 3; b++) begin
          xfer(0, mo_v[b], 8, r);
          tick(5);
          tests++;
          if (rx_byte[0] !== mo_v[b]) begin fails++; $display("FAIL b2b_rx_byte%0d: got %h, required %h", b, rx_byte[0], mo_v[b]); end
          tests++;
          if (r !== mi_v[b]) begin fails++; $display("FAIL b2b_miso_byte%0d: got %h, required %h", b, r, mi_v[b]); end
        end
        cs_high(0);
      end
      begin
        tx_load(0, 8'h44);
        tx_load(0, 8'h55);
      end
    join
    tests++;
    if (dv_cnt[0] - d0 !== 3) begin fails++; $display("FAIL b2b_dv_pulses: got %0d, required 3", dv_cnt[0] - d0); end
  endtask

  task automatic test_underrun();
    logic [7:0] r;
    int d0, u0;
    d0 = dv_cnt[1];
    u0 = ur_cnt[1];
    cs_low(1);
    tx_load(1, 8'h77);   // after the frame-start boundary, so it covers the closing boundary
    xfer(1, 8'hC7, 8, r);
    cs_high(1);
    tests++;
    if (r !== 8'hFF) begin fails++; $display("FAIL ur_miso_byte: got %h, required ff", r); end
    tests++;
    if (ur_cnt[1] - u0 !== 1) begin fails++; $display("FAIL ur_pulses: got %0d, required 1", ur_cnt[1] - u0); end
    tests++;
    if (rx_byte[1] !== 8'hC7) begin fails++; $display("FAIL ur_rx_byte: got %h, required c7", rx_byte[1]); end
    tests++;
    if (dv_cnt[1] - d0 !== 1) begin fails++; $display("FAIL ur_dv_pulses: got %0d, required 1", dv_cnt[1] - d0); end
  endtask

  task automatic test_cs_abort();
    logic [7:0] r;
    int d0;
    d0 = dv_cnt[0];
    cs_low(0);
    tests++;
    if (miso_en[0] !== 1'b1) begin fails++; $display("FAIL abort_en_active: got %b, required 1", miso_en[0]); end
    xfer(0, 8'hE7, 5, r);
    cs_high(0);
    tests++;
    if (dv_cnt[0] - d0 !== 0) begin fails++; $display("FAIL abort_partial_dv: got %0d, required 0", dv_cnt[0] - d0); end
    tests++;
    if (miso_en[0] !== 1'b0) begin fails++; $display("FAIL abort_en_idle: got %b, required 0", miso_en[0]); end
    cs_low(0);
    xfer(0, 8'h5A, 8, r);
    cs_high(0);
    tests++;
    if (rx_byte[0] !== 8'h5A) begin fails++; $display("FAIL abort_rx_byte: got %h, required 5a", rx_byte[0]); end
    tests++;
    if (dv_cnt[0] - d0 !== 1) begin fails++; $display("FAIL abort_dv_pulses: got %0d, required 1", dv_cnt[0] - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r;
    tx_load(0, 8'h96);
    tx_byte[0] = 8'h69;
    tx_dv[0]   = 1'b1;
    tick(1);
    tx_dv[0]   = 1'b0;
    tests++;
    if (tx_ready[0] !== 1'b0) begin fails++; $display("FAIL ignored_dv_ready: got %b, required 0", tx_ready[0]); end
    cs_low(0);
    xfer(0, 8'hF0, 4, r);
    tests++;
    if (r[7:4] !== 4'h9) begin fails++; $display("FAIL held_byte_bits: got %h, required 9", r[7:4]); end
    rst_l = 1'b0;
    #1;
    tests++;
    if ({rx_dv[0], rx_byte[0], tx_ready[0], underrun[0], miso[0], miso_en[0]} !== 13'b0_00000000_1_0_0_0) begin
      fails++;
      $display("FAIL midframe_reset: dv=%b rx=%h rdy=%b ur=%b miso=%b en=%b, required 0 00 1 0 0 0",
               rx_dv[0], rx_byte[0], tx_ready[0], underrun[0], miso[0], miso_en[0]);
    end
    cs_n[0] = 1'b1;
    sclk[0] = 1'b0;
    mosi[0] = 1'b0;
    tick(2);
    rst_l = 1'b1;
    tick(4);
    tests++;
    if (miso_en[0] !== 1'b0) begin fails++; $display("FAIL post_reset_en: got %b, required 0", miso_en[0]); end
    cs_low(0);
    xfer(0, 8'h3F, 8, r);
    cs_high(0);
    tests++;
    if (r !== 8'hFF) begin fails++; $display("FAIL post_reset_miso: got %h, required ff", r); end
    tests++;
    if (rx_byte[0] !== 8'h3F) begin fails++; $display("FAIL post_reset_rx: got %h, required 3f", rx_byte[0]); end
  endtask

  initial begin
    sclk  = 4'b1100;
    cs_n  = 4'hF;
    mosi  = 4'h0;
    tx_dv = 4'h0;
    for (int m = 0; m < 4; m++) tx_byte[m] = 8'h00;
    test_reset();
    test_mode0_basic();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_cs_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
